seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph ROM, segment bit
// positions and output polarity helpers.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high glyphs {a,b,c,d,e,f,g}; entry 15 (F) is written first.
    localparam logic [15:0][SEG_A:SEG_G] GLYPH_TBL = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic logic inactive_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [SEG_A:SEG_G] seg_polarity(input logic [SEG_A:SEG_G] glyph,
                                                         input bit active_low);
        return active_low ? ~glyph : glyph;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/control inputs and pin-level outputs of the scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank;
    logic                    lz_en;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output value_in, dp_in, load, blank, lz_en,
        input  seg_out, dp_out, an_out, frame_done
    );

    modport slave (
        input  value_in, dp_in, load, blank, lz_en,
        output seg_out, dp_out, an_out, frame_done
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph; usable on its own
// wherever a single static digit is needed.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]          nib_i,
    output logic [SEG_A:SEG_G]  glyph_o
);

    always_comb begin
        glyph_o = GLYPH_TBL[nib_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment driver with frame-aligned double
// buffering, leading-zero suppression, blanking and anti-ghost guard time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 1,
    parameter bit ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_driver_if.slave bus
);

    localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW  = $clog2(NUM_DIGITS);
    localparam int   VW  = 4 * NUM_DIGITS;
    localparam logic OFF = inactive_level(ACTIVE_LOW);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_q, pend_d;
    logic                  frame_q;
    logic [SEG_A:SEG_G]    seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick, wrap;
    logic [3:0]            cur_nib;
    logic [SEG_A:SEG_G]    cur_glyph;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  zrun;
    logic                  suppress;
    logic [NUM_DIGITS-1:0] an_on;
    logic                  dp_on;

    always_comb begin
        tick    = (presc_q == PW'(REFRESH_DIV - 1));
        wrap    = tick && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Loads land in the pending buffer; active only changes on the wrap tick,
    // and a load on that very tick bypasses pending so it shows next frame.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        if (bus.load) begin
            pend_val_d = bus.value_in;
            pend_dp_d  = bus.dp_in;
            pend_d     = 1'b1;
        end
        if (wrap) begin
            pend_d = 1'b0;
            if (bus.load) begin
                act_val_d = bus.value_in;
                act_dp_d  = bus.dp_in;
            end else if (pend_q) begin
                act_val_d = pend_val_q;
                act_dp_d  = pend_dp_q;
            end
        end
    end

    always_comb begin
        zero_from = '0;
        zrun      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun         = zrun && (act_val_q[4*i +: 4] == 4'h0);
            zero_from[i] = zrun;
        end
    end

    assign cur_nib = act_val_q[4*int'(idx_q) +: 4];

    seg7_hex_decode u_dec (
        .nib_i   (cur_nib),
        .glyph_o (cur_glyph)
    );

    always_comb begin
        suppress     = bus.lz_en && (idx_q != '0) && zero_from[idx_q];
        an_on        = '0;
        an_on[idx_q] = 1'b1;
        if ((int'(presc_q) < GUARD_CYCLES) || bus.blank || suppress) begin
            an_on = '0;
        end
        dp_on = act_dp_q[idx_q] && !suppress;
        an_d  = ACTIVE_LOW ? ~an_on : an_on;
        dp_d  = ACTIVE_LOW ? ~dp_on : dp_on;
        seg_d = seg_polarity(cur_glyph, ACTIVE_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= {7{OFF}};
            dp_q       <= OFF;
            an_q       <= {NUM_DIGITS{OFF}};
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            frame_q    <= wrap;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.an_out     = an_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots, 1 guard
// cycle and active-low outputs.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inverted glyph table, hand-derived from the active-high glyphs.
    logic [6:0] exp_glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where frame_done is high; n = cycles advanced.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 64);
        if (!bus.frame_done) chk("frame_timeout", {31'b0, bus.frame_done}, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        bus.value_in = v;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    int n;
    int lit [4];

    initial begin
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank    = 1'b0;
        bus.lz_en    = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an",  bus.an_out,     4'b1111);
        chk("rst_seg", bus.seg_out,    7'b1111111);
        chk("rst_dp",  bus.dp_out,     1'b1);
        chk("rst_fd",  bus.frame_done, 1'b0);
        rst = 1'b0;
        adv(1);
        chk("post_rst_guard", bus.an_out, 4'b1111);
        adv(1);
        chk("post_rst_d0_an",  bus.an_out,  4'b1110);
        chk("post_rst_d0_seg", bus.seg_out, 7'b0000001);

        // 12AF with dp on digit 2
        load_val(16'h12AF, 4'b0100);
        wait_frame(n);
        adv(2);
        chk("12af_d0_an",  bus.an_out,  4'b1110);
        chk("12af_d0_seg", bus.seg_out, 7'b0111000);
        chk("12af_d0_dp",  bus.dp_out,  1'b1);
        adv(4);
        chk("12af_d1_seg", bus.seg_out, 7'b0001000);
        adv(4);
        chk("12af_d2_an",  bus.an_out,  4'b1011);
        chk("12af_d2_seg", bus.seg_out, 7'b0010010);
        chk("12af_d2_dp",  bus.dp_out,  1'b0);
        wait_frame(n);
        for (int i = 0; i < 4; i++) lit[i] = 0;
        for (int c = 0; c < 16; c++) begin
            adv(1);
            for (int i = 0; i < 4; i++) if (bus.an_out[i] == 1'b0) lit[i]++;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("duty_d%0d", i), lit[i], 32'd3);

        // Glyph sweep on digit 0
        for (int g = 0; g < 16; g++) begin
            load_val(16'(g), 4'b0000);
            wait_frame(n);
            adv(2);
            chk($sformatf("glyph_%0h", g), bus.seg_out, exp_glyph[g]);
        end

        // Leading-zero suppression
        bus.lz_en = 1'b1;
        load_val(16'h0050, 4'b0000);
        wait_frame(n);
        adv(2);
        chk("lz50_d0_an",  bus.an_out,  4'b1110);
        chk("lz50_d0_seg", bus.seg_out, 7'b0000001);
        adv(4);
        chk("lz50_d1_an",  bus.an_out,  4'b1101);
        chk("lz50_d1_seg", bus.seg_out, 7'b0100100);
        adv(4);
        chk("lz50_d2_an",  bus.an_out,  4'b1111);
        adv(4);
        chk("lz50_d3_an",  bus.an_out,  4'b1111);
        load_val(16'h0000, 4'b0000);
        wait_frame(n);
        adv(2);
        chk("lz00_d0_an", bus.an_out, 4'b1110);
        adv(4);
        chk("lz00_d1_an", bus.an_out, 4'b1111);
        adv(4);
        chk("lz00_d2_an", bus.an_out, 4'b1111);
        adv(4);
        chk("lz00_d3_an", bus.an_out, 4'b1111);
        bus.lz_en = 1'b0;

        // Double buffering: mid-frame load waits for the next frame
        wait_frame(n);
        adv(2);
        load_val(16'h1234, 4'b0000);
        adv(3);
        chk("db_hold_d1_seg", bus.seg_out, 7'b0000001);
        wait_frame(n);
        adv(2);
        chk("db_new_d0_seg", bus.seg_out, 7'b1001100);

        // Two loads in one frame: last wins
        load_val(16'h5678, 4'b0000);
        adv(2);
        load_val(16'h9ABC, 4'b0000);
        wait_frame(n);
        adv(2);
        chk("db_last_d0_seg", bus.seg_out, 7'b0110001);
        adv(4);
        chk("db_last_d1_seg", bus.seg_out, 7'b1100000);

        // Load coincident with the wrap tick
        wait_frame(n);
        adv(15);
        bus.value_in = 16'hDEAD;
        bus.dp_in    = 4'b0000;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        chk("wrap_load_fd", bus.frame_done, 1'b1);
        adv(2);
        chk("wrap_load_d0_seg", bus.seg_out, 7'b1000010);
        adv(8);
        chk("wrap_load_d2_seg", bus.seg_out, 7'b0110000);

        // Blank: anodes off, scanning continues
        bus.blank = 1'b1;
        adv(1);
        chk("blank_an_next", bus.an_out, 4'b1111);
        wait_frame(n);
        n = 0;
        for (int c = 0; c < 16; c++) begin
            adv(1);
            if (bus.an_out != 4'b1111) n++;
        end
        chk("blank_lit_cycles", n, 32'd0);
        wait_frame(n);
        adv(2);
        chk("blank_seg_driven", bus.seg_out, 7'b1000010);
        bus.blank = 1'b0;

        // Async reset mid-slot discards the pending load
        wait_frame(n);
        adv(2);
        load_val(16'h1111, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an",  bus.an_out,  4'b1111);
        chk("arst_seg", bus.seg_out, 7'b1111111);
        chk("arst_dp",  bus.dp_out,  1'b1);
        adv(2);
        rst = 1'b0;
        adv(1);
        chk("arst_guard_an", bus.an_out, 4'b1111);
        adv(1);
        chk("arst_d0_an",  bus.an_out,  4'b1110);
        chk("arst_d0_seg", bus.seg_out, 7'b0000001);
        wait_frame(n);
        chk("arst_first_frame_len", n + 2, 32'd16);
        adv(2);
        chk("arst_pending_lost", bus.seg_out, 7'b0000001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
